// File: rtl/quad_gate_tester_pkg.sv
// Shared definitions for the quad 2-input gate tester.
// Holds the gate-function encodings, the FSM state encoding, the number of
// test vectors and the fixed (A,B) vector table that every gate receives.
package quad_gate_tester_pkg;

    localparam int NUM_VECTORS = 4;
    localparam int NUM_GATES   = 4;
    localparam int IDX_W       = 2;

    typedef enum logic [2:0] {
        FUNC_OR   = 3'd0,
        FUNC_AND  = 3'd1,
        FUNC_NAND = 3'd2,
        FUNC_NOR  = 3'd3,
        FUNC_XOR  = 3'd4,
        FUNC_XNOR = 3'd5,
        FUNC_RSV6 = 3'd6,
        FUNC_RSV7 = 3'd7
    } func_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    typedef struct packed {
        logic a;
        logic b;
    } vec_t;

    // Index 0..3 = (0,0), (0,1), (1,0), (1,1); leftmost element is index 3.
    localparam vec_t [NUM_VECTORS-1:0] VEC_TABLE = {
        vec_t'(2'b11), vec_t'(2'b10), vec_t'(2'b01), vec_t'(2'b00)
    };

    function automatic logic func_is_legal(input logic [2:0] code);
        return (code <= 3'd5);
    endfunction

endpackage

// File: rtl/quad_gate_tester_gate_ref.sv
// gate_ref: purely combinational reference model of one 2-input gate.
// Ports:
//   func_i  gate function code (func_e)
//   a_i     A input bit
//   b_i     B input bit
//   y_o     expected output, replicated across all four gates
// Reserved codes produce 0; the tester never checks against them.
module gate_ref
    import quad_gate_tester_pkg::*;
(
    input  func_e                func_i,
    input  logic                 a_i,
    input  logic                 b_i,
    output logic [NUM_GATES-1:0] y_o
);

    logic exp_bit;

    always_comb begin
        exp_bit = 1'b0;
        case (func_i)
            FUNC_OR:   exp_bit = a_i | b_i;
            FUNC_AND:  exp_bit = a_i & b_i;
            FUNC_NAND: exp_bit = ~(a_i & b_i);
            FUNC_NOR:  exp_bit = ~(a_i | b_i);
            FUNC_XOR:  exp_bit = a_i ^ b_i;
            FUNC_XNOR: exp_bit = ~(a_i ^ b_i);
            default:   exp_bit = 1'b0;
        endcase
    end

    assign y_o = {NUM_GATES{exp_bit}};

endmodule

// File: rtl/quad_gate_tester.sv
// quad_gate_tester: functional tester for a quad 2-input logic gate device.
// Walks the four (A,B) vectors, holds each for SETTLE_CYCLES clocks, then
// compares all four gate outputs against the selected function.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   START           one-cycle run request (honoured only in IDLE)
//   FUNC_SEL[2:0]   expected gate function (6, 7 reserved)
//   A[3:0], B[3:0]  stimulus to gates 1..4 (bit 0 = gate 1)
//   Y[3:0]          gate outputs returned from the device
//   BUSY            run in progress
//   DONE            one-cycle end-of-run pulse
//   PASS            last run result
//   FAIL_MASK[3:0]  sticky per-gate mismatch flags
//   FAIL_VEC[1:0]   index of the first failing vector
// All outputs are registered.
module quad_gate_tester
    import quad_gate_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
)(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [2:0]           FUNC_SEL,
    output logic [NUM_GATES-1:0] A,
    output logic [NUM_GATES-1:0] B,
    input  logic [NUM_GATES-1:0] Y,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [NUM_GATES-1:0] FAIL_MASK,
    output logic [IDX_W-1:0]     FAIL_VEC
);

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_e                 state_q;
    func_e                  func_q;
    logic [IDX_W-1:0]       idx_q;
    logic [7:0]             cnt_q;
    logic [NUM_GATES-1:0]   a_q;
    logic [NUM_GATES-1:0]   b_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;
    logic [NUM_GATES-1:0]   fail_mask_q;
    logic [IDX_W-1:0]       fail_vec_q;

    logic [NUM_GATES-1:0]   exp_y;
    logic [NUM_GATES-1:0]   mism;
    logic [NUM_GATES-1:0]   fail_mask_d;
    logic [IDX_W-1:0]       idx_d;
    vec_t                   next_vec;

    // All four gates see the same pair, so gate 1's stimulus is representative.
    gate_ref u_gate_ref (
        .func_i (func_q),
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .y_o    (exp_y)
    );

    assign mism        = Y ^ exp_y;
    assign fail_mask_d = fail_mask_q | mism;
    assign idx_d       = idx_q + 2'd1;
    assign next_vec    = VEC_TABLE[idx_d];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            func_q      <= FUNC_OR;
            idx_q       <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
            fail_vec_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        if (func_is_legal(FUNC_SEL)) begin
                            func_q      <= func_e'(FUNC_SEL);
                            fail_mask_q <= '0;
                            fail_vec_q  <= '0;
                            pass_q      <= 1'b0;
                            idx_q       <= '0;
                            busy_q      <= 1'b1;
                            // Vector 0 is driven on the edge APPLY is entered.
                            a_q         <= {NUM_GATES{VEC_TABLE[0].a}};
                            b_q         <= {NUM_GATES{VEC_TABLE[0].b}};
                            state_q     <= ST_APPLY;
                        end else begin
                            // Reserved function: report an immediate total failure.
                            fail_mask_q <= '1;
                            fail_vec_q  <= '0;
                            pass_q      <= 1'b0;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            a_q         <= '0;
                            b_q         <= '0;
                            state_q     <= ST_FINISH;
                        end
                    end
                end
                ST_APPLY: begin
                    cnt_q   <= CNT_LOAD;
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= ST_CHECK;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_CHECK: begin
                    fail_mask_q <= fail_mask_d;
                    // First failing vector is the one seen while the mask was still clear.
                    if (fail_mask_q == '0 && mism != '0) begin
                        fail_vec_q <= idx_q;
                    end
                    if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
                        // DONE/PASS/BUSY are registered, so they take effect while in FINISH.
                        done_q  <= 1'b1;
                        pass_q  <= (fail_mask_d == '0);
                        busy_q  <= 1'b0;
                        a_q     <= '0;
                        b_q     <= '0;
                        state_q <= ST_FINISH;
                    end else begin
                        idx_q   <= idx_d;
                        a_q     <= {NUM_GATES{next_vec.a}};
                        b_q     <= {NUM_GATES{next_vec.b}};
                        state_q <= ST_APPLY;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign FAIL_MASK = fail_mask_q;
    assign FAIL_VEC  = fail_vec_q;

endmodule

// File: tb/tb_quad_gate_tester.sv
module tb_quad_gate_tester;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, start1;
    logic [2:0] func_sel0, func_sel1;
    logic [3:0] a0, b0, y0, a1, b1, y1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [3:0] mask0, mask1;
    logic [1:0] fvec0, fvec1;

    // Device model for instance 0: 0 = quad OR, 1 = quad OR with gate 3 stuck at 0, 2 = quad XOR
    int mode;

    always_comb begin
        y0 = a0 | b0;
        if (mode == 1) y0[2] = 1'b0;
        if (mode == 2) y0 = a0 ^ b0;
    end

    assign y1 = a1 ^ b1;

    quad_gate_tester #(.SETTLE_CYCLES(4)) dut0 (
        .CLK(clk), .RST(rst), .START(start0), .FUNC_SEL(func_sel0),
        .A(a0), .B(b0), .Y(y0), .BUSY(busy0), .DONE(done0),
        .PASS(pass0), .FAIL_MASK(mask0), .FAIL_VEC(fvec0)
    );

    quad_gate_tester #(.SETTLE_CYCLES(1)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .FUNC_SEL(func_sel1),
        .A(a1), .B(b1), .Y(y1), .BUSY(busy1), .DONE(done1),
        .PASS(pass1), .FAIL_MASK(mask1), .FAIL_VEC(fvec1)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts a run on dut0 from a falling edge and returns the number of
    // cycles until DONE is seen. With mid_start set, extra START pulses are
    // issued at cycles 3 and 10 and FUNC_SEL is changed mid-run.
    task automatic run0(input logic [2:0] fs, input bit mid_start, output int lat);
        func_sel0 = fs;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        lat = 1;
        while (done0 !== 1'b1 && lat < 100) begin
            if (lat == 7) begin
                chk("a_vec1", a0, 4'h0);
                chk("b_vec1", b0, 4'hF);
            end
            if (lat == 19) begin
                chk("a_vec3", a0, 4'hF);
                chk("b_vec3", b0, 4'hF);
            end
            start0 = mid_start && (lat == 3 || lat == 10);
            if (mid_start && lat == 5) func_sel0 = 3'd7;
            @(negedge clk);
            lat++;
        end
        start0 = 1'b0;
    endtask

    int lat;
    int seen;

    initial begin
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        func_sel0 = 3'd0; func_sel1 = 3'd0;
        mode = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_pass", pass0, 1'b0);
        chk("rst_mask", mask0, 4'h0);
        chk("rst_fvec", fvec0, 2'd0);
        chk("rst_ab", {a0, b0}, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Correct OR device, OR expected
        mode = 0;
        run0(3'd0, 1'b0, lat);
        chk("or_lat", lat, 25);
        chk("or_pass", pass0, 1'b1);
        chk("or_mask", mask0, 4'h0);
        chk("or_fvec", fvec0, 2'd0);
        chk("or_ab_fin", {a0, b0}, 8'h00);
        chk("or_busy_fin", busy0, 1'b0);
        @(negedge clk);
        chk("or_done_pulse", done0, 1'b0);
        repeat (3) @(negedge clk);
        chk("or_pass_hold", pass0, 1'b1);

        // OR device, AND expected: first mismatch on (0,1)
        run0(3'd1, 1'b0, lat);
        chk("and_lat", lat, 25);
        chk("and_pass", pass0, 1'b0);
        chk("and_mask", mask0, 4'hF);
        chk("and_fvec", fvec0, 2'd1);
        @(negedge clk);

        // Gate 3 stuck at 0
        mode = 1;
        run0(3'd0, 1'b0, lat);
        chk("stuck_pass", pass0, 1'b0);
        chk("stuck_mask", mask0, 4'b0100);
        chk("stuck_fvec", fvec0, 2'd1);
        @(negedge clk);
        mode = 0;

        // OR device, NAND expected: fails on vector 0
        run0(3'd2, 1'b0, lat);
        chk("nand_pass", pass0, 1'b0);
        chk("nand_mask", mask0, 4'hF);
        chk("nand_fvec", fvec0, 2'd0);
        @(negedge clk);

        // OR device, XOR expected: only vector 3 fails
        run0(3'd4, 1'b0, lat);
        chk("xor_or_pass", pass0, 1'b0);
        chk("xor_or_mask", mask0, 4'hF);
        chk("xor_or_fvec", fvec0, 2'd3);
        @(negedge clk);

        // Extra STARTs and FUNC_SEL change during the run are ignored
        run0(3'd0, 1'b1, lat);
        chk("mid_lat", lat, 25);
        chk("mid_pass", pass0, 1'b1);
        chk("mid_mask", mask0, 4'h0);
        @(negedge clk);
        chk("mid_busy_after", busy0, 1'b0);

        // Reserved function code
        run0(3'd7, 1'b0, lat);
        chk("rsv_lat", lat, 1);
        chk("rsv_mask", mask0, 4'hF);
        chk("rsv_pass", pass0, 1'b0);
        chk("rsv_fvec", fvec0, 2'd0);
        // START while in FINISH is ignored
        func_sel0 = 3'd0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("fin_start_busy", busy0, 1'b0);
        chk("rsv_done_pulse", done0, 1'b0);
        @(negedge clk);
        chk("fin_start_busy2", busy0, 1'b0);

        // RST has priority over START
        rst = 1'b1; start0 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start0 = 1'b0;
        chk("rst_prio_busy", busy0, 1'b0);
        chk("rst_prio_mask", mask0, 4'h0);

        // Reset during SETTLE of vector 2
        func_sel0 = 3'd0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        lat = 1;
        while (lat < 14) begin
            @(negedge clk);
            lat++;
        end
        chk("pre_rst_busy", busy0, 1'b1);
        chk("pre_rst_a", a0, 4'hF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy0, 1'b0);
        chk("abort_ab", {a0, b0}, 8'h00);
        chk("abort_done", done0, 1'b0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done0 === 1'b1) seen++;
        end
        chk("abort_no_done", seen, 0);
        run0(3'd0, 1'b0, lat);
        chk("post_rst_lat", lat, 25);
        chk("post_rst_pass", pass0, 1'b1);
        @(negedge clk);

        // SETTLE_CYCLES=1, XOR device
        func_sel1 = 3'd4;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 1;
        while (done1 !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("s1_xor_lat", lat, 13);
        chk("s1_xor_pass", pass1, 1'b1);
        chk("s1_xor_mask", mask1, 4'h0);
        @(negedge clk);

        // SETTLE_CYCLES=1, XOR device, XNOR expected: fails on vector 0
        func_sel1 = 3'd5;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 1;
        while (done1 !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("s1_xnor_lat", lat, 13);
        chk("s1_xnor_pass", pass1, 1'b0);
        chk("s1_xnor_mask", mask1, 4'hF);
        chk("s1_xnor_fvec", fvec1, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/quad_gate_tester.md
QUAD_GATE_TESTER -- requirements
Module: quad_gate_tester

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, is the number of clocks each vector is held before its outputs are sampled; legal range 1..255.
REQ-002 CLK  input  1  single clock; all logic is on the rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 START  input  1  one-cycle request to begin a test run; honoured only in IDLE.
REQ-005 FUNC_SEL  input  3  expected gate function: 0 OR, 1 AND, 2 NAND, 3 NOR, 4 XOR, 5 XNOR; 6 and 7 are reserved.
REQ-006 A  output  4  A-inputs driven to DUT gates 1..4 (bit 0 = gate 1).
REQ-007 B  output  4  B-inputs driven to DUT gates 1..4.
REQ-008 Y  input  4  DUT gate outputs Y1..Y4 (bit 0 = gate 1).
REQ-009 BUSY  output  1  high while a run is in progress.
REQ-010 DONE  output  1  one-cycle pulse at the end of a run.
REQ-011 PASS  output  1  result of the last run; valid from the DONE pulse until the next START.
REQ-012 FAIL_MASK  output  4  sticky per-gate mismatch flags for the last run.
REQ-013 FAIL_VEC  output  2  index of the first failing vector; 0 when PASS=1.

Function
REQ-014 The FSM has exactly five states: IDLE, APPLY, SETTLE, CHECK, FINISH.
REQ-015 In IDLE with START=1 and a legal FUNC_SEL, the block latches FUNC_SEL and clears FAIL_MASK, FAIL_VEC and PASS. It sets vector index to 0, asserts BUSY and moves to APPLY.
REQ-016 In IDLE with START=1 and FUNC_SEL of 6 or 7, the block goes directly to FINISH with PASS=0, FAIL_MASK=4'hF and FAIL_VEC=0.
REQ-017 The vector sequence is fixed as index 0..3 = (A,B) of (0,0), (0,1), (1,0), (1,1); all four gates receive the same pair.
REQ-018 APPLY drives A and B for the current index on the same edge it is entered, loads the settle counter with SETTLE_CYCLES-1 and moves to SETTLE on the next cycle.
REQ-019 SETTLE decrements the settle counter each cycle and moves to CHECK when the counter equals 0. With SETTLE_CYCLES=1, SETTLE lasts exactly one cycle.
REQ-020 CHECK compares Y against the expected 4-bit result for the latched function and the current vector in a single cycle.
REQ-021 On a mismatch in CHECK, the block ORs the mismatching bits into FAIL_MASK. If FAIL_MASK was 0 before this CHECK, it also records the current index in FAIL_VEC.
REQ-022 After CHECK at index 3 the block moves to FINISH; at any other index it increments the index and returns to APPLY.
REQ-023 A and B hold their values throughout SETTLE and CHECK.
REQ-024 Total run latency from START to DONE is 4*(SETTLE_CYCLES+2)+1 cycles: 25 cycles with SETTLE_CYCLES=4.
REQ-025 FINISH pulses DONE for one cycle, sets PASS=1 iff FAIL_MASK==0, drives A=B=0, deasserts BUSY and returns to IDLE.
REQ-026 START while BUSY=1 is ignored. FUNC_SEL changes during a run have no effect.
REQ-027 START in the same cycle as FINISH is ignored; a new run needs START in IDLE.
REQ-028 PASS, FAIL_MASK and FAIL_VEC hold their values in IDLE until the next accepted START.

Reset
REQ-029 With RST=1 at a clock edge, the state becomes IDLE, A=B=0, BUSY=DONE=PASS=0, FAIL_MASK=0, FAIL_VEC=0, and the index and settle counter are 0.
REQ-030 Reset mid-run aborts the run with no DONE pulse. RST takes priority over START in the same cycle.

Structure
REQ-031 A shared package holds the FUNC_SEL encodings, the FSM state encoding, the constant NUM_VECTORS=4 and the 4-entry vector table.
REQ-032 Expected-output generation is a purely combinational sub-module, gate_ref, instantiated once. Inputs: function code, A bit, B bit. Output: expected Y bit, replicated across the four gates.

Verification
REQ-033 FUNC_SEL=0 with a correct quad-OR DUT, SETTLE_CYCLES=4, START pulse -> DONE exactly 25 cycles later, PASS=1, FAIL_MASK=0, FAIL_VEC=0.
REQ-034 FUNC_SEL=1 with a quad-OR DUT -> PASS=0, FAIL_MASK=4'hF, FAIL_VEC=1 (vector (0,1) is the first mismatch).
REQ-035 FUNC_SEL=0 with an OR DUT whose gate 3 output is stuck at 0 -> PASS=0, FAIL_MASK=4'b0100, FAIL_VEC=1.
REQ-036 RST asserted during SETTLE of vector 2 -> next cycle BUSY=0, A=B=0, no DONE pulse; a subsequent START runs a full, correct test.
REQ-037 Second START pulses at cycles 3 and 10 of a run -> ignored, and the run completes at 25 cycles. Separately, FUNC_SEL=7 with START -> DONE on the next cycle with FAIL_MASK=4'hF.
REQ-038 SETTLE_CYCLES=1 with an XOR DUT and FUNC_SEL=4 -> DONE 13 cycles after START, PASS=1.
